// File: rtl/tocador_pkg.sv
// Shared types and constants for the note-sequence player.
// Optional feature macro used by this slice: TOCADOR_RETEM_EN (retain buffer, limpa port).
package tocador_pkg;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        TOCA   = 2'd1,
        PAUSA  = 2'd2,
        FIM    = 2'd3
    } estado_t;

    localparam logic [3:0] NOTA_125HZ = 4'b0001;
    localparam logic [3:0] NOTA_250HZ = 4'b0010;
    localparam logic [3:0] NOTA_333HZ = 4'b0100;
    localparam logic [3:0] NOTA_500HZ = 4'b1000;
    localparam logic [3:0] SILENCIO   = 4'b0000;

    // A note code is usable only when exactly one bit is set.
    function automatic logic nota_valida(input logic [3:0] nota);
        return (nota != 4'b0000) && ((nota & (nota - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/fila_notas.sv
// Synchronous note FIFO. Besides normal push/pop it keeps a separate read
// index (r_idx) that can be rewound to the oldest entry and stepped forward,
// which lets the player replay the buffer without consuming it.
module fila_notas #(
    parameter int DEPTH = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         i_push,
    input  logic [3:0]                   i_dado,
    input  logic                         i_pop,
    input  logic                         i_avanca,
    input  logic                         i_rebobina,
    input  logic                         i_limpa,
    output logic [3:0]                   o_primeira,
    output logic [3:0]                   o_cabeca,
    output logic [$clog2(DEPTH+1)-1:0]   o_qtd,
    output logic                         o_cheio,
    output logic                         o_vazio,
    output logic                         o_restam
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [3:0]    r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_idx;
    logic [CW-1:0] r_qtd;
    logic [CW-1:0] r_lidos;
    logic          w_push_ok;
    logic          w_pop_ok;

    // Clearing the buffer takes priority over any push or pop in the same cycle.
    assign w_push_ok = i_push && !i_limpa && (r_qtd != CW'(DEPTH));
    assign w_pop_ok  = i_pop  && !i_limpa && (r_qtd != '0);

    // Note storage; contents are only meaningful between the read and write pointers.
    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_mem[r_wr] <= i_dado;
        end
    end

    // Pointers, count and the replay index; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset || i_limpa) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_idx   <= '0;
            r_qtd   <= '0;
            r_lidos <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd <= r_rd + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_qtd <= r_qtd + CW'(1);
                2'b01:   r_qtd <= r_qtd - CW'(1);
                default: r_qtd <= r_qtd;
            endcase
            if (i_rebobina) begin
                r_idx   <= r_rd;
                r_lidos <= '0;
            end else if (i_avanca) begin
                r_idx   <= r_idx + AW'(1);
                r_lidos <= r_lidos + CW'(1);
            end
        end
    end

    assign o_primeira = r_mem[r_rd];
    assign o_cabeca   = r_mem[r_idx];
    assign o_qtd      = r_qtd;
    assign o_cheio    = (r_qtd == CW'(DEPTH));
    assign o_vazio    = (r_qtd == '0);
    assign o_restam   = (r_lidos != r_qtd);

endmodule

// File: rtl/tocador_sequencia.sv
// Note-sequence player feeding the buzzer tone generator. Buffers one-hot
// notes and plays them back as TEMPO_NOTA cycles of tone followed by
// TEMPO_PAUSA silent cycles each.
// Optional feature macro: TOCADOR_RETEM_EN -- playback does not consume the
// buffer, every start replays from the oldest note, and a limpa port clears it.
module tocador_sequencia
    import tocador_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int TEMPO_NOTA  = 500,
    parameter int TEMPO_PAUSA = 100
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         escreve,
    input  logic [3:0]                   nota,
    input  logic                         iniciar,
`ifdef TOCADOR_RETEM_EN
    input  logic                         limpa,
`endif
    output logic                         conta,
    output logic [3:0]                   seletor,
    output logic                         ocupado,
    output logic                         fim,
    output logic                         cheio,
    output logic                         vazio,
    output logic [$clog2(DEPTH+1)-1:0]   qtd
);

    localparam int MAXT = (TEMPO_NOTA > TEMPO_PAUSA) ? TEMPO_NOTA : TEMPO_PAUSA;
    localparam int TW   = (MAXT > 1) ? $clog2(MAXT) : 1;

`ifdef TOCADOR_RETEM_EN
    localparam bit RETEM = 1'b1;
`else
    localparam bit RETEM = 1'b0;
`endif

    estado_t       r_estado;
    estado_t       w_prox;
    logic [TW-1:0] r_timer;
    logic          r_conta;
    logic [3:0]    r_seletor;
    logic          r_ocupado;
    logic          r_fim;

    logic          w_limpa;
    logic          w_escrita_ok;
    logic          w_avanca;
    logic          w_rebobina;
    logic          w_pop;
    logic          w_ha_mais;
    logic          w_restam;
    logic [3:0]    w_primeira;
    logic [3:0]    w_cabeca;
    logic [3:0]    w_seletor_prox;

`ifdef TOCADOR_RETEM_EN
    assign w_limpa = limpa && (r_estado == OCIOSO);
`else
    assign w_limpa = 1'b0;
`endif

    assign w_escrita_ok = escreve && (r_estado == OCIOSO) && nota_valida(nota)
                          && !cheio && !w_limpa;

    // In retain mode the buffer is only walked, never popped.
    assign w_pop     = w_avanca && !RETEM;
    assign w_ha_mais = RETEM ? w_restam : !vazio;

    fila_notas #(
        .DEPTH(DEPTH)
    ) u_fila (
        .clock      (clock),
        .reset      (reset),
        .i_push     (w_escrita_ok),
        .i_dado     (nota),
        .i_pop      (w_pop),
        .i_avanca   (w_avanca),
        .i_rebobina (w_rebobina),
        .i_limpa    (w_limpa),
        .o_primeira (w_primeira),
        .o_cabeca   (w_cabeca),
        .o_qtd      (qtd),
        .o_cheio    (cheio),
        .o_vazio    (vazio),
        .o_restam   (w_restam)
    );

    // Next-state logic plus the note to show next; a note written in the start cycle is bypassed straight to seletor.
    always_comb begin
        w_prox         = r_estado;
        w_avanca       = 1'b0;
        w_rebobina     = 1'b0;
        w_seletor_prox = SILENCIO;
        case (r_estado)
            OCIOSO: begin
                if (iniciar) begin
                    w_rebobina = 1'b1;
                    w_prox     = ((!vazio && !w_limpa) || w_escrita_ok) ? TOCA : FIM;
                end
            end
            TOCA: begin
                if (r_timer == TW'(TEMPO_NOTA - 1)) begin
                    w_prox   = PAUSA;
                    w_avanca = 1'b1;
                end
            end
            PAUSA: begin
                if (r_timer == TW'(TEMPO_PAUSA - 1)) begin
                    w_prox = w_ha_mais ? TOCA : FIM;
                end
            end
            FIM: begin
                w_prox = OCIOSO;
            end
            default: begin
                w_prox = OCIOSO;
            end
        endcase
        if (w_prox == TOCA) begin
            case (r_estado)
                OCIOSO:  w_seletor_prox = vazio ? nota : w_primeira;
                PAUSA:   w_seletor_prox = w_cabeca;
                default: w_seletor_prox = r_seletor;
            endcase
        end
    end

    // State register and phase timer; the timer restarts from zero on every state change.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado <= OCIOSO;
            r_timer  <= '0;
        end else begin
            r_estado <= w_prox;
            if ((w_prox != r_estado) || (r_estado == OCIOSO)) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TW'(1);
            end
        end
    end

    // Registered outputs decoded from the upcoming state so they line up with it cycle for cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_conta   <= 1'b0;
            r_seletor <= SILENCIO;
            r_ocupado <= 1'b0;
            r_fim     <= 1'b0;
        end else begin
            r_conta   <= (w_prox == TOCA);
            r_seletor <= w_seletor_prox;
            r_ocupado <= (w_prox != OCIOSO);
            r_fim     <= (w_prox == FIM);
        end
    end

    assign conta   = r_conta;
    assign seletor = r_seletor;
    assign ocupado = r_ocupado;
    assign fim     = r_fim;

endmodule
